// File: rtl/round_sequencer_pkg.sv
// round_pkg: opcode, challenge-word field and FSM state constants shared by the round sequencer
package round_pkg;
    localparam logic [1:0] OP_BOTAO       = 2'b00;
    localparam logic [1:0] OP_BOTAO_SERVO = 2'b01;
    localparam logic [1:0] OP_SERVO       = 2'b10;
    localparam logic [1:0] OP_SENSOR      = 2'b11;
    localparam int OP_MSB   = 59;
    localparam int OP_LSB   = 58;
    localparam int LEDS_MSB = 57;
    localparam int LEDS_LSB = 54;
    localparam int POS_MSB  = 53;
    localparam int POS_LSB  = 52;
    localparam int INF_MSB  = 51;
    localparam int INF_LSB  = 40;
    localparam int SUP_MSB  = 39;
    localparam int SUP_LSB  = 28;
    localparam int EXP_MSB  = 27;
    localparam int EXP_LSB  = 0;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_PRESENT = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
endpackage

// File: rtl/round_sequencer_if.sv
// round_sequencer_if: ROM, answer front-end and display/servo signals of the round sequencer
interface round_sequencer_if;
    logic        iniciar;
    logic [59:0] rom_data;
    logic [27:0] codigo;
    logic        codigo_valid;
    logic [11:0] medida;
    logic        medida_valid;
    logic [2:0]  address;
    logic [3:0]  leds;
    logic [1:0]  pos_servo;
    logic        servo_en;
    logic [3:0]  acertos;
    logic        rodada_ok;
    logic        rodada_erro;
    logic        pronto;
    logic [2:0]  estado;
    modport master (
        output iniciar, rom_data, codigo, codigo_valid, medida, medida_valid,
        input  address, leds, pos_servo, servo_en, acertos, rodada_ok, rodada_erro, pronto, estado
    );
    modport slave (
        input  iniciar, rom_data, codigo, codigo_valid, medida, medida_valid,
        output address, leds, pos_servo, servo_en, acertos, rodada_ok, rodada_erro, pronto, estado
    );
endinterface

// File: rtl/round_timer.sv
// round_timer: clearable enabled counter pulsing tc on the CYCLES-th enabled cycle
module round_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
    logic [W-1:0] cnt;
    assign tc = en && cnt == W'(CYCLES - 1);
    // count enabled cycles, restarting on clear or terminal count
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt <= '0;
        else if (clr || tc) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: walks the challenge ROM one round at a time and scores answers (ROUND_TIMEOUT_EN adds an answer timeout)
module round_sequencer
    import round_pkg::*;
#(
    parameter int NUM_ROUNDS     = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int PRESENT_CYCLES = 1000
) (
    input logic clock,
    input logic reset,
    round_sequencer_if.slave bus
);
    logic [2:0]  state;
    logic [59:0] word;
    logic [27:0] ans;
    logic        timed_out;
    logic [2:0]  address;
    logic [3:0]  acertos;
    logic        present_tc;
    logic        wait_tc;
    logic [1:0]  op;
    logic        sensor;
    logic        accept;
    logic        hit;
    logic        showing;

    assign op      = word[OP_MSB:OP_LSB];
    assign sensor  = op == OP_SENSOR;
    assign accept  = sensor ? bus.medida_valid : bus.codigo_valid;
    assign hit     = !timed_out && (sensor ? (ans[11:0] >= word[INF_MSB:INF_LSB] && ans[11:0] <= word[SUP_MSB:SUP_LSB])
                                           : ans == word[EXP_MSB:EXP_LSB]);
    assign showing = state >= S_PRESENT && state <= S_CHECK;

    round_timer #(.CYCLES(PRESENT_CYCLES)) u_present (
        .clock(clock), .reset(reset), .clr(state != S_PRESENT), .en(state == S_PRESENT), .tc(present_tc)
    );
`ifdef ROUND_TIMEOUT_EN
    round_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock(clock), .reset(reset), .clr(state != S_WAIT), .en(state == S_WAIT), .tc(wait_tc)
    );
`else
    assign wait_tc = 1'b0;
`endif

    // round FSM: latch word, present, capture answer, score, advance
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state     <= S_IDLE;
            word      <= '0;
            ans       <= '0;
            timed_out <= 1'b0;
            address   <= '0;
            acertos   <= '0;
        end else
            case (state)
                S_IDLE, S_DONE:
                    if (bus.iniciar) begin
                        acertos <= '0;
                        address <= '0;
                        state   <= S_LOAD;
                    end
                S_LOAD: begin
                    word  <= bus.rom_data;
                    state <= S_PRESENT;
                end
                S_PRESENT: if (present_tc) state <= S_WAIT;
                S_WAIT:
                    if (accept) begin
                        ans   <= sensor ? {16'b0, bus.medida} : bus.codigo;
                        state <= S_CHECK;
                    end else if (wait_tc) begin
                        timed_out <= 1'b1;
                        state     <= S_CHECK;
                    end
                S_CHECK: begin
                    if (hit && acertos != 4'hF) acertos <= acertos + 4'd1;
                    timed_out <= 1'b0;
                    state     <= S_NEXT;
                end
                S_NEXT:
                    if (address == 3'(NUM_ROUNDS - 1)) state <= S_DONE;
                    else begin
                        address <= address + 3'd1;
                        state   <= S_LOAD;
                    end
                default: state <= S_IDLE;
            endcase

    assign bus.address     = address;
    assign bus.acertos     = acertos;
    assign bus.estado      = state;
    assign bus.leds        = showing ? word[LEDS_MSB:LEDS_LSB] : 4'd0;
    assign bus.pos_servo   = showing ? word[POS_MSB:POS_LSB] : 2'd0;
    assign bus.servo_en    = showing && (op == OP_BOTAO_SERVO || op == OP_SERVO);
    assign bus.rodada_ok   = state == S_CHECK && hit;
    assign bus.rodada_erro = state == S_CHECK && !hit;
    assign bus.pronto      = state == S_DONE;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed games against a ROM model with a scoreboard of expected round results
module tb_round_sequencer;
    import round_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    round_sequencer_if bus ();
    logic [59:0] rom [8];
    bit sb [$];
    int n_checks = 0;
    int n_fail = 0;

    round_sequencer #(.NUM_ROUNDS(8), .TIMEOUT_CYCLES(20), .PRESENT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;
    assign bus.rom_data = rom[bus.address];

    function automatic logic [27:0] c4(input logic [31:0] s);
        return {s[30:24], s[22:16], s[14:8], s[6:0]};
    endfunction

    function automatic logic [59:0] mk(input logic [1:0] op, input logic [3:0] l, input logic [1:0] p,
                                       input logic [11:0] inf, input logic [11:0] sup, input logic [27:0] e);
        return {op, l, p, inf, sup, e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every result pulse pops the expected outcome of that round
    always @(negedge clock)
        if (!reset && (bus.rodada_ok || bus.rodada_erro)) begin
            if (sb.size() == 0) chk("unexpected_pulse", {bus.rodada_ok, bus.rodada_erro}, 2'b00);
            else begin
                bit e;
                e = sb.pop_front();
                chk("round_result", {bus.rodada_ok, bus.rodada_erro}, {e, !e});
            end
        end

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (bus.estado !== s && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("wait_state", bus.estado, s);
    endtask

    task automatic start();
        @(negedge clock);
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
    endtask

    task automatic check_present();
        logic [59:0] w;
        w = rom[bus.address];
        chk("leds", bus.leds, w[57:54]);
        chk("pos_servo", bus.pos_servo, w[53:52]);
        chk("servo_en", bus.servo_en, w[59:58] == 2'b01 || w[59:58] == 2'b10);
    endtask

    task automatic answer(input bit med, input logic [27:0] cod, input logic [11:0] m, input bit exp_ok);
        wait_state(S_WAIT);
        check_present();
        sb.push_back(exp_ok);
        if (med) begin
            bus.medida = m;
            bus.medida_valid = 1'b1;
        end else begin
            bus.codigo = cod;
            bus.codigo_valid = 1'b1;
        end
        @(negedge clock);
        bus.medida_valid = 1'b0;
        bus.codigo_valid = 1'b0;
        chk("strobe_to_check", bus.estado, S_CHECK);
    endtask

    task automatic ignored(input bit med, input logic [27:0] cod, input logic [11:0] m);
        wait_state(S_WAIT);
        if (med) begin
            bus.medida = m;
            bus.medida_valid = 1'b1;
        end else begin
            bus.codigo = cod;
            bus.codigo_valid = 1'b1;
        end
        @(negedge clock);
        bus.medida_valid = 1'b0;
        bus.codigo_valid = 1'b0;
        chk("ignored_strobe", bus.estado, S_WAIT);
    endtask

    task automatic good_round();
        logic [59:0] w;
        wait_state(S_WAIT);
        w = rom[bus.address];
        answer(w[59:58] == 2'b11, w[27:0], 12'h015, 1'b1);
    endtask

    task automatic finish_game(input logic [3:0] exp_acertos);
        wait_state(S_DONE);
        chk("acertos", bus.acertos, exp_acertos);
        chk("pronto", bus.pronto, 1'b1);
        chk("address_done", bus.address, 3'd7);
        chk("leds_done", bus.leds, 4'd0);
        chk("servo_en_done", bus.servo_en, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rom[0] = mk(2'b00, 4'b0001, 2'd0, 12'h000, 12'h000, c4("A1B2"));
        rom[1] = mk(2'b01, 4'b0011, 2'd1, 12'h000, 12'h000, c4("C3D4"));
        rom[2] = mk(2'b10, 4'b0111, 2'd2, 12'h000, 12'h000, c4("E5F6"));
        rom[3] = mk(2'b11, 4'b1000, 2'd3, 12'h010, 12'h025, 28'd0);
        rom[4] = mk(2'b00, 4'b1100, 2'd0, 12'h000, 12'h000, c4("G7H8"));
        rom[5] = mk(2'b01, 4'b1010, 2'd2, 12'h000, 12'h000, c4("J9K0"));
        rom[6] = mk(2'b11, 4'b0101, 2'd1, 12'h010, 12'h025, 28'd0);
        rom[7] = mk(2'b10, 4'b1111, 2'd3, 12'h000, 12'h000, c4("L!M?"));
        bus.iniciar = 1'b0;
        bus.codigo = '0;
        bus.codigo_valid = 1'b0;
        bus.medida = '0;
        bus.medida_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_estado", bus.estado, S_IDLE);
        chk("rst_outputs", {bus.address, bus.leds, bus.pos_servo, bus.servo_en, bus.acertos,
                            bus.rodada_ok, bus.rodada_erro, bus.pronto}, 0);
        reset = 1'b0;
        // game 1: all answers correct
        start();
        for (int r = 0; r < 8; r++) good_round();
        finish_game(4'd8);
        // game 2: wrong code, sensor low bound, medida ignored in button round, sensor high bound
        start();
        answer(1'b0, c4("Y$2#"), 12'h0, 1'b0);
        wait_state(S_LOAD);
        chk("miss_acertos", bus.acertos, 4'd0);
        chk("miss_address", bus.address, 3'd1);
        good_round();
        good_round();
        answer(1'b1, 28'd0, 12'h010, 1'b1);
        good_round();
        ignored(1'b1, 28'd0, 12'h015);
        good_round();
        answer(1'b1, 28'd0, 12'h025, 1'b1);
        good_round();
        finish_game(4'd7);
        // game 3: sensor just above and just below the window
        start();
        for (int r = 0; r < 3; r++) good_round();
        answer(1'b1, 28'd0, 12'h026, 1'b0);
        good_round();
        good_round();
        answer(1'b1, 28'd0, 12'h009, 1'b0);
        good_round();
        finish_game(4'd6);
        // game 4: codigo ignored in sensor round, both strobes together
        start();
        for (int r = 0; r < 3; r++) good_round();
        ignored(1'b0, 28'd0, 12'h0);
        answer(1'b1, 28'd0, 12'h020, 1'b1);
        good_round();
        good_round();
        wait_state(S_WAIT);
        sb.push_back(1'b0);
        bus.codigo = 28'd0;
        bus.medida = 12'h030;
        bus.codigo_valid = 1'b1;
        bus.medida_valid = 1'b1;
        @(negedge clock);
        bus.codigo_valid = 1'b0;
        bus.medida_valid = 1'b0;
        chk("both_to_check", bus.estado, S_CHECK);
        good_round();
        finish_game(4'd7);
        // game 5: reset in round 3 WAIT, then restart
        start();
        for (int r = 0; r < 3; r++) good_round();
        wait_state(S_WAIT);
        chk("round3_address", bus.address, 3'd3);
        reset = 1'b1;
        #1;
        chk("midreset_estado", bus.estado, S_IDLE);
        chk("midreset_outputs", {bus.address, bus.leds, bus.pos_servo, bus.servo_en, bus.acertos,
                                 bus.rodada_ok, bus.rodada_erro, bus.pronto}, 0);
        @(negedge clock);
        reset = 1'b0;
        start();
        wait_state(S_LOAD);
        chk("restart_address", bus.address, 3'd0);
        chk("restart_acertos", bus.acertos, 4'd0);
`ifdef ROUND_TIMEOUT_EN
        begin
            int n = 0;
            wait_state(S_WAIT);
            sb.push_back(1'b0);
            while (!bus.rodada_erro && n < 100) begin
                @(negedge clock);
                n++;
            end
            chk("timeout_cycles", n, 20);
            wait_state(S_WAIT);
            repeat (19) @(negedge clock);
            chk("late_still_wait", bus.estado, S_WAIT);
            sb.push_back(1'b1);
            bus.codigo = c4("C3D4");
            bus.codigo_valid = 1'b1;
            @(negedge clock);
            bus.codigo_valid = 1'b0;
            chk("late_strobe_check", bus.estado, S_CHECK);
            for (int r = 2; r < 8; r++) good_round();
            finish_game(4'd7);
        end
`else
        for (int r = 0; r < 8; r++) good_round();
        finish_game(4'd8);
`endif
        repeat (2) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
